min_select_seq: RTL and testbench

MIN_SELECT_SEQ -- requirements
Module: min_select_seq

---
 rtl/min_select_seq_if.sv | 69 ++++++
 rtl/min_select_seq.sv | 124 ++++++++++++
 tb/tb_min_select_seq.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/min_select_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | min_select_seq_if : candidate/result handshake bundle for            |
// |                     min_select_seq (MIN_SELECT_SEQ_MASK_EN adds mask)|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface min_select_seq_if #(
    parameter int WIDTH = 7,
    parameter int TAG_W = 7,
    parameter int CNT_W = 3
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_ene;
    logic [TAG_W-1:0] in_tag;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_ene;
    logic [TAG_W-1:0] out_tag;
    logic [CNT_W-1:0] out_cnt;
    logic             busy;
`ifdef MIN_SELECT_SEQ_MASK_EN
    logic             in_mask;
    logic             out_none;
`endif

    // Requester side: issues start, supplies candidates, collects the result.
    modport master (
        output start,
        output in_valid,
        input  in_ready,
        output in_ene,
        output in_tag,
        output in_last,
`ifdef MIN_SELECT_SEQ_MASK_EN
        output in_mask,
        input  out_none,
`endif
        input  out_valid,
        output out_ready,
        input  out_ene,
        input  out_tag,
        input  out_cnt,
        input  busy
    );

    // Search engine side.
    modport slave (
        input  start,
        input  in_valid,
        output in_ready,
        input  in_ene,
        input  in_tag,
        input  in_last,
`ifdef MIN_SELECT_SEQ_MASK_EN
        input  in_mask,
        output out_none,
`endif
        output out_valid,
        input  out_ready,
        output out_ene,
        output out_tag,
        output out_cnt,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/min_select_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | min_select_seq : sequential minimum-energy selector over up to N     |
// |                  tagged candidates. Option: MIN_SELECT_SEQ_MASK_EN   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module min_select_seq #(
    parameter int WIDTH    = 7,
    parameter int TAG_W    = 7,
    parameter int N        = 4,
    parameter int TIE_LAST = 1
) (
    input  wire logic        m_clock,
    input  wire logic        p_reset,
    min_select_seq_if.slave  bus
);
    localparam int              c_cnt_w    = $clog2(N + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(N);
    localparam logic [WIDTH-1:0]   c_ene_max = {WIDTH{1'b1}};
    localparam logic               c_tie_last = (TIE_LAST != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic [WIDTH-1:0]   r_min;
    logic [TAG_W-1:0]   r_tag;
    logic [c_cnt_w-1:0] r_cnt;
    // Set until the first comparable candidate lands; doubles as "all masked".
    logic               r_none;

    logic               w_accept;
    logic               w_masked;
    logic               w_take;
    logic               w_end;
    logic [c_cnt_w-1:0] w_cnt_next;

`ifdef MIN_SELECT_SEQ_MASK_EN
    assign w_masked = bus.in_mask;
`else
    assign w_masked = 1'b0;
`endif

    // r_in_ready is only ever high in ACC, so this is the ACC-side handshake.
    assign w_accept   = bus.in_valid & r_in_ready;
    assign w_cnt_next = r_cnt + c_cnt_w'(1);
    assign w_end      = bus.in_last | (w_cnt_next == c_cnt_max);
    assign w_take     = w_accept & ~w_masked &
                        (r_none | (bus.in_ene < r_min) |
                         (c_tie_last & (bus.in_ene == r_min)));

    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_min       <= c_ene_max;
            r_tag       <= '0;
            r_cnt       <= '0;
            r_none      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state    <= ACC;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_min      <= c_ene_max;
                        r_tag      <= '0;
                        r_cnt      <= '0;
                        r_none     <= 1'b1;
                    end
                end
                ACC: begin
                    if (w_accept) begin
                        r_cnt <= w_cnt_next;
                        if (w_take) begin
                            r_min  <= bus.in_ene;
                            r_tag  <= bus.in_tag;
                            r_none <= 1'b0;
                        end
                        if (w_end) begin
                            r_state     <= DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.out_ene   = r_min;
    assign bus.out_tag   = r_tag;
    assign bus.out_cnt   = r_cnt;
`ifdef MIN_SELECT_SEQ_MASK_EN
    assign bus.out_none  = r_none;
`endif

endmodule
`default_nettype wire

// File: tb/tb_min_select_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_min_select_seq : directed bench for min_select_seq, TIE_LAST=1    |
// |                     and TIE_LAST=0 instances share one stimulus      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_min_select_seq;
    logic m_clock;
    logic p_reset;
    int   n_cmp;
    int   n_bad;

    min_select_seq_if #(.WIDTH(7), .TAG_W(7), .CNT_W(3)) bus ();
    min_select_seq_if #(.WIDTH(7), .TAG_W(7), .CNT_W(3)) bus0 ();

    min_select_seq #(.WIDTH(7), .TAG_W(7), .N(4), .TIE_LAST(1)) u_dut (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .bus     (bus)
    );

    min_select_seq #(.WIDTH(7), .TAG_W(7), .N(4), .TIE_LAST(0)) u_dut0 (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .bus     (bus0)
    );

    assign bus0.start     = bus.start;
    assign bus0.in_valid  = bus.in_valid;
    assign bus0.in_ene    = bus.in_ene;
    assign bus0.in_tag    = bus.in_tag;
    assign bus0.in_last   = bus.in_last;
    assign bus0.out_ready = bus.out_ready;
`ifdef MIN_SELECT_SEQ_MASK_EN
    assign bus0.in_mask   = bus.in_mask;
`endif

    initial m_clock = 1'b0;
    always #5 m_clock = ~m_clock;

    task automatic tick();
        @(posedge m_clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [6:0] ene, input logic [6:0] tag, input logic last);
        bus.in_valid = 1'b1;
        bus.in_ene   = ene;
        bus.in_tag   = tag;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

`ifdef MIN_SELECT_SEQ_MASK_EN
    task automatic send_m(input logic [6:0] ene, input logic [6:0] tag, input logic last,
                          input logic mask);
        bus.in_mask = mask;
        send(ene, tag, last);
        bus.in_mask = 1'b0;
    endtask
`endif

    task automatic begin_search();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        p_reset       = 1'b1;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_ene    = '0;
        bus.in_tag    = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
`ifdef MIN_SELECT_SEQ_MASK_EN
        bus.in_mask   = 1'b0;
`endif
        tick();
        tick();
        chk("rst_in_ready",  32'(bus.in_ready),  32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_busy",      32'(bus.busy),      32'h0);
        chk("rst_ene",       32'(bus.out_ene),   32'h7f);
        chk("rst_tag",       32'(bus.out_tag),   32'h0);
        chk("rst_cnt",       32'(bus.out_cnt),   32'h0);
        p_reset = 1'b0;
        tick();

        // Basic search: minimum 3 from tag 2
        begin_search();
        chk("acc_in_ready", 32'(bus.in_ready), 32'h1);
        chk("acc_busy",     32'(bus.busy),     32'h1);
        send(7'd5, 7'd1, 1'b0);
        send(7'd3, 7'd2, 1'b0);
        send(7'd9, 7'd4, 1'b0);
        chk("mid_out_valid", 32'(bus.out_valid), 32'h0);
        send(7'd6, 7'd8, 1'b1);
        chk("b_out_valid", 32'(bus.out_valid), 32'h1);
        chk("b_in_ready",  32'(bus.in_ready),  32'h0);
        chk("b_ene",       32'(bus.out_ene),   32'h3);
        chk("b_tag",       32'(bus.out_tag),   32'h2);
        chk("b_cnt",       32'(bus.out_cnt),   32'h4);
        chk("b0_tag",      32'(bus0.out_tag),  32'h2);
        release_result();
        chk("b_idle_valid", 32'(bus.out_valid), 32'h0);
        chk("b_idle_busy",  32'(bus.busy),      32'h0);
        chk("b_idle_ene",   32'(bus.out_ene),   32'h3);

        // Tie rule: later wins with TIE_LAST=1, earliest with 0
        begin_search();
        send(7'd4, 7'd1, 1'b0);
        send(7'd4, 7'd2, 1'b1);
        chk("tie1_tag", 32'(bus.out_tag),  32'h2);
        chk("tie0_tag", 32'(bus0.out_tag), 32'h1);
        chk("tie_cnt",  32'(bus.out_cnt),  32'h2);
        release_result();

        // N limit: fourth candidate terminates without in_last
        begin_search();
        send(7'd10, 7'd1, 1'b0);
        send(7'd11, 7'd2, 1'b0);
        send(7'd12, 7'd3, 1'b0);
        send(7'd13, 7'd4, 1'b0);
        chk("n_out_valid", 32'(bus.out_valid), 32'h1);
        chk("n_in_ready",  32'(bus.in_ready),  32'h0);
        chk("n_cnt",       32'(bus.out_cnt),   32'h4);
        send(7'd1, 7'd5, 1'b0);
        chk("n5_ene", 32'(bus.out_ene), 32'ha);
        chk("n5_tag", 32'(bus.out_tag), 32'h1);
        chk("n5_cnt", 32'(bus.out_cnt), 32'h4);

        // Back-pressure: result held, start ignored
        bus.start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_valid", 32'(bus.out_valid), 32'h1);
            chk("stall_ene",   32'(bus.out_ene),   32'ha);
            chk("stall_cnt",   32'(bus.out_cnt),   32'h4);
        end
        bus.start = 1'b0;
        release_result();
        chk("stall_rel_valid", 32'(bus.out_valid), 32'h0);
        chk("stall_rel_busy",  32'(bus.busy),      32'h0);
        chk("stall_rel_ene",   32'(bus.out_ene),   32'ha);

        // Asynchronous reset mid-search
        begin_search();
        send(7'd20, 7'd1, 1'b0);
        send(7'd21, 7'd2, 1'b0);
        p_reset = 1'b1;
        #1;
        chk("ar_busy",     32'(bus.busy),      32'h0);
        chk("ar_in_ready", 32'(bus.in_ready),  32'h0);
        chk("ar_valid",    32'(bus.out_valid), 32'h0);
        chk("ar_ene",      32'(bus.out_ene),   32'h7f);
        chk("ar_cnt",      32'(bus.out_cnt),   32'h0);
        tick();
        p_reset = 1'b0;
        tick();
        send(7'd2, 7'd1, 1'b1);
        chk("nostart_busy",  32'(bus.busy),      32'h0);
        chk("nostart_valid", 32'(bus.out_valid), 32'h0);
        chk("nostart_ene",   32'(bus.out_ene),   32'h7f);
        begin_search();
        send(7'd2, 7'd1, 1'b1);
        chk("ar2_valid", 32'(bus.out_valid), 32'h1);
        chk("ar2_ene",   32'(bus.out_ene),   32'h2);
        chk("ar2_tag",   32'(bus.out_tag),   32'h1);
        chk("ar2_cnt",   32'(bus.out_cnt),   32'h1);
        release_result();

        // First candidate all-ones is still taken under TIE_LAST=0
        begin_search();
        send(7'h7f, 7'd9, 1'b1);
        chk("first_tag0", 32'(bus0.out_tag), 32'h9);
        release_result();

`ifdef MIN_SELECT_SEQ_MASK_EN
        begin_search();
        send_m(7'd1, 7'd1, 1'b0, 1'b1);
        send_m(7'd8, 7'd2, 1'b0, 1'b0);
        send_m(7'd7, 7'd4, 1'b1, 1'b1);
        chk("mask_ene",  32'(bus.out_ene),  32'h8);
        chk("mask_tag",  32'(bus.out_tag),  32'h2);
        chk("mask_cnt",  32'(bus.out_cnt),  32'h3);
        chk("mask_none", 32'(bus.out_none), 32'h0);
        release_result();
        begin_search();
        send_m(7'd5, 7'd1, 1'b0, 1'b1);
        send_m(7'd6, 7'd2, 1'b1, 1'b1);
        chk("allm_none", 32'(bus.out_none), 32'h1);
        chk("allm_ene",  32'(bus.out_ene),  32'h7f);
        chk("allm_tag",  32'(bus.out_tag),  32'h0);
        chk("allm_cnt",  32'(bus.out_cnt),  32'h2);
        release_result();
        p_reset = 1'b1;
        #1;
        chk("mask_rst_none", 32'(bus.out_none), 32'h0);
        tick();
        p_reset = 1'b0;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
